axi_burst_init_master: RTL

AXI_BURST_INIT_MASTER -- requirements
Module: axi_burst_init_master

---
 rtl/axi_burst_init_master.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/axi_burst_init_master.sv
// AXI4 write master that fills memory with an arithmetic data sequence in INCR bursts.
// Define AXI_INIT_ERR_STOP_EN to end the job on the first non-OKAY write response.
module axi_burst_init_master #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [15:0]               num_words,
    input  logic [DATA_WIDTH-1:0]     seed_data,
    input  logic [DATA_WIDTH-1:0]     data_incr,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [7:0]                err_count,
    output logic [ADDR_WIDTH-1:0]     M_AXI_awaddr,
    output logic [7:0]                M_AXI_awlen,
    output logic [2:0]                M_AXI_awsize,
    output logic [1:0]                M_AXI_awburst,
    output logic                      M_AXI_awvalid,
    input  logic                      M_AXI_awready,
    output logic [DATA_WIDTH-1:0]     M_AXI_wdata,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_wstrb,
    output logic                      M_AXI_wlast,
    output logic                      M_AXI_wvalid,
    input  logic                      M_AXI_wready,
    input  logic [1:0]                M_AXI_bresp,
    input  logic                      M_AXI_bvalid,
    output logic                      M_AXI_bready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_RESP = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           remaining;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] incr_q;
    logic [8:0]            burst_beats;
    logic [8:0]            beat_cnt;
    logic                  error_q;
    logic [7:0]            err_cnt_q;

    logic [12:0]           to_4k_bytes;
    logic [12:0]           to_4k_beats;
    logic [8:0]            rem_cap;
    logic [8:0]            next_beats;
    logic                  last_beat;
    logic                  bad_resp;

    // Burst size is the smallest of words left, the burst cap, and beats to the next 4 KB page.
    always_comb begin
        to_4k_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
        to_4k_beats = to_4k_bytes >> SIZE;
        rem_cap     = (remaining > 16'(MAX_BURST_LEN)) ? 9'(MAX_BURST_LEN) : remaining[8:0];
        next_beats  = ({4'b0, rem_cap} > to_4k_beats) ? to_4k_beats[8:0] : rem_cap;
    end

    assign last_beat = (beat_cnt == burst_beats - 9'd1);
    assign bad_resp  = (M_AXI_bresp != 2'b00);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            remaining   <= '0;
            wdata_q     <= '0;
            incr_q      <= '0;
            burst_beats <= '0;
            beat_cnt    <= '0;
            error_q     <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q    <= base_addr;
                        remaining <= num_words;
                        wdata_q   <= seed_data;
                        incr_q    <= data_incr;
                        error_q   <= 1'b0;
                        err_cnt_q <= '0;
                        state     <= (num_words == 16'd0) ? S_FIN : S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (M_AXI_awready) begin
                        burst_beats <= next_beats;
                        beat_cnt    <= '0;
                        state       <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (M_AXI_wready) begin
                        wdata_q <= wdata_q + incr_q;
                        if (last_beat) begin
                            state <= S_RESP;
                        end else begin
                            beat_cnt <= beat_cnt + 9'd1;
                        end
                    end
                end
                S_RESP: begin
                    if (M_AXI_bvalid) begin
                        addr_q    <= addr_q + (ADDR_WIDTH'(burst_beats) << SIZE);
                        remaining <= remaining - 16'(burst_beats);
                        if (bad_resp) begin
                            error_q <= 1'b1;
                            if (err_cnt_q != 8'hFF) begin
                                err_cnt_q <= err_cnt_q + 8'd1;
                            end
                        end
`ifdef AXI_INIT_ERR_STOP_EN
                        if (bad_resp || remaining == 16'(burst_beats)) begin
                            state <= S_FIN;
                        end else begin
                            state <= S_ADDR;
                        end
`else
                        state <= (remaining == 16'(burst_beats)) ? S_FIN : S_ADDR;
`endif
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode straight from state so reset clears them asynchronously.
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_FIN);
    assign error         = error_q;
    assign err_count     = err_cnt_q;
    assign M_AXI_awaddr  = addr_q;
    assign M_AXI_awlen   = 8'(next_beats - 9'd1);
    assign M_AXI_awsize  = 3'(SIZE);
    assign M_AXI_awburst = 2'b01;
    assign M_AXI_awvalid = (state == S_ADDR);
    assign M_AXI_wdata   = wdata_q;
    assign M_AXI_wstrb   = '1;
    assign M_AXI_wlast   = (state == S_DATA) && last_beat;
    assign M_AXI_wvalid  = (state == S_DATA);
    assign M_AXI_bready  = (state == S_RESP);

endmodule
